// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline register with 2-entry skid buffer and flush
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    // EMPTY: nothing held; ONE: main live; FULL: main and skid live
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [1:0]          occupancy_q, occupancy_d;

    logic                fire_in;
    logic                fire_out;

    // Handshakes are formed only from registered flags, so in_ready never
    // sees out_ready combinationally.
    assign fire_in  = in_valid & in_ready_q;
    assign fire_out = out_valid_q & out_ready;

    // Next-state, storage moves and registered status flags
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        if (flush) begin
            // Kill everything; the same-cycle input is dropped, not accepted.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (fire_in) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                        state_d     = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (fire_in && fire_out) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else if (fire_in) begin
                        // Downstream stalled: park the younger word in the skid.
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                        state_d     = ST_FULL;
                    end else if (fire_out) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (fire_out) begin
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        state_d     = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
        case (state_d)
            ST_ONE:  occupancy_d = 2'd1;
            ST_FULL: occupancy_d = 2'd2;
            default: occupancy_d = 2'd0;
        endcase
    end

    // State and payload registers; reset discards every entry at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occupancy_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            occupancy_q <= occupancy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_data_q;
    // A bubble must decode as a NOP downstream, whatever main_ctrl still holds.
    assign out_ctrl  = out_valid_q ? main_ctrl_q : '0;
    assign occupancy = occupancy_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - vector table plus scoreboard bench for pipe_stage_skid
module tb_pipe_stage_skid;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [7:0]  in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_ctrl;
    logic [1:0]  occupancy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        iv;
        logic        ordy;
        logic        fl;
        logic [31:0] d;
        logic        exp_ov;
        logic        exp_ir;
        logic [1:0]  exp_occ;
        logic        chk_d;
        logic [31:0] exp_d;
    } vec_t;

    vec_t        vecs[$];
    logic [39:0] sb[$];

    pipe_stage_skid #(.DATA_W(32), .CTRL_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ctrl_of(input logic [31:0] d);
        return d[7:0] ^ 8'hA5;
    endfunction

    task automatic add(input logic iv, input logic ordy, input logic fl, input logic [31:0] d,
                       input logic ov, input logic ir, input logic [1:0] occ,
                       input logic chk, input logic [31:0] ed);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.d = d;
        v.exp_ov = ov; v.exp_ir = ir; v.exp_occ = occ; v.chk_d = chk; v.exp_d = ed;
        vecs.push_back(v);
    endtask

    // Starts just after a falling edge: drive, score the live handshake, cross the rising edge.
    task automatic do_cycle(input logic iv, input logic ordy, input logic fl, input logic [31:0] d);
        logic [39:0] e;
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        in_data   = d;
        in_ctrl   = iv ? ctrl_of(d) : 8'hFF;
        #2;
        if (!out_valid) check("bubble_ctrl", {24'd0, out_ctrl}, 32'd0);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out_fire", out_data, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("sb_data", out_data, e[39:8]);
                check("sb_ctrl", {24'd0, out_ctrl}, {24'd0, e[7:0]});
            end
        end
        if (flush) sb.delete();
        else if (in_valid && in_ready) sb.push_back({in_data, in_ctrl});
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_out_ctrl"}, {24'd0, out_ctrl}, 32'd0);
        check({tag, "_out_data"}, out_data, 32'd0);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_occupancy"}, {30'd0, occupancy}, 32'd0);
    endtask

    initial begin
        // Streaming 1..8 at full rate, then drain
        for (int i = 1; i <= 8; i++) add(1, 1, 0, i, 1, 1, 2'd1, 1, i);
        add(0, 1, 0, 0, 0, 1, 2'd0, 0, 0);
        // Stall with A,B; a further offer while full is ignored; release drains A then B
        add(1, 0, 0, 32'hA0A0_0001, 1, 1, 2'd1, 1, 32'hA0A0_0001);
        add(1, 0, 0, 32'hB0B0_0002, 1, 0, 2'd2, 1, 32'hA0A0_0001);
        add(1, 0, 0, 32'hDEAD_BEEF, 1, 0, 2'd2, 1, 32'hA0A0_0001);
        add(0, 1, 0, 0, 1, 1, 2'd1, 1, 32'hB0B0_0002);
        add(0, 1, 0, 0, 0, 1, 2'd0, 0, 0);
        // Flush while FULL with C offered: C dropped, nothing left
        add(1, 0, 0, 32'h11, 1, 1, 2'd1, 0, 0);
        add(1, 0, 0, 32'h22, 1, 0, 2'd2, 0, 0);
        add(1, 0, 1, 32'hCCCC, 0, 1, 2'd0, 0, 0);
        add(0, 1, 0, 0, 0, 1, 2'd0, 0, 0);
        add(1, 1, 0, 32'h33, 1, 1, 2'd1, 1, 32'h33);
        add(0, 1, 0, 0, 0, 1, 2'd0, 0, 0);
        // Flush in ONE with same-cycle out fire: 0x44 still delivered, 0x55 dropped
        add(1, 0, 0, 32'h44, 1, 1, 2'd1, 0, 0);
        add(1, 1, 1, 32'h55, 0, 1, 2'd0, 0, 0);
        // Bubbles mid-stream with in_ctrl=FF
        add(1, 1, 0, 32'h61, 1, 1, 2'd1, 0, 0);
        add(0, 1, 0, 0, 0, 1, 2'd0, 0, 0);
        add(1, 1, 0, 32'h62, 1, 1, 2'd1, 0, 0);
        add(1, 1, 0, 32'h63, 1, 1, 2'd1, 1, 32'h63);
        add(0, 1, 0, 0, 0, 1, 2'd0, 0, 0);
        // Release from FULL while upstream keeps offering
        add(1, 0, 0, 32'h71, 1, 1, 2'd1, 0, 0);
        add(1, 0, 0, 32'h72, 1, 0, 2'd2, 0, 0);
        add(1, 1, 0, 32'h73, 1, 1, 2'd1, 1, 32'h72);
        add(1, 1, 0, 32'h74, 1, 1, 2'd1, 1, 32'h74);
        add(0, 1, 0, 0, 0, 1, 2'd0, 0, 0);

        // Reset held with random inputs
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            flush     = 1'($urandom);
            in_data   = $urandom;
            in_ctrl   = 8'($urandom);
            @(negedge clk);
        end
        check_reset_outputs("reset");
        in_valid = 0; out_ready = 0; flush = 0;
        rst = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            do_cycle(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].d);
            check($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].exp_ov});
            check($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].exp_ir});
            check($sformatf("v%0d_occupancy", i), {30'd0, occupancy}, {30'd0, vecs[i].exp_occ});
            if (vecs[i].chk_d) check($sformatf("v%0d_out_data", i), out_data, vecs[i].exp_d);
            @(negedge clk);
        end

        // Async reset pulse between edges while FULL
        do_cycle(1, 0, 0, 32'h81);
        @(negedge clk);
        do_cycle(1, 0, 0, 32'h82);
        check("pre_areset_occupancy", {30'd0, occupancy}, 32'd2);
        @(negedge clk);
        in_valid = 0; out_ready = 0;
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("areset");
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        // Clean traffic afterwards
        for (int i = 0; i < 3; i++) begin
            do_cycle(1, 1, 0, 32'h90 + i);
            check("post_areset_out_data", out_data, 32'h90 + i);
            @(negedge clk);
        end
        do_cycle(0, 1, 0, 0);
        check("post_areset_drained", {30'd0, occupancy}, 32'd0);
        @(negedge clk);

        check("sb_empty_at_end", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
